// File: rtl/riscv_pkg.sv
// Shared loader types and sizing helpers for the instruction-memory loader.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_t;

  // Default cache capacity and the word-count sizing derived from it.
  localparam int unsigned SIZE_DEFAULT = 8192;
  localparam int unsigned WORDS        = SIZE_DEFAULT / 4;
  localparam int unsigned CNT_W        = $clog2(WORDS) + 1;

  // Counter width for a given capacity, able to hold the value SIZE/4 itself.
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size / 4) + 1;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream link in, cache write port out. Master is the loader.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, we, waddr, wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words; used for header and data.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;

  // The word completes on the edge accepting its 4th byte, so present it
  // combinationally with the incoming byte merged into the top lane.
  assign word       = {byte_in, sh_q[31:8]};
  assign word_valid = byte_en && (cnt_q == 2'd3);

  // Next byte position and shift contents; first byte drifts down to [7:0].
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr) begin
      cnt_d = 2'd0;
      sh_d  = 32'd0;
    end else if (byte_en) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = {byte_in, sh_q[31:8]};
    end
  end

  // Byte counter and assembly register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      sh_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time L1 I-cache writer: header word N, then N data words, holding the core until done.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned SIZE = 8192,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  imem_loader_if.master  bus,
  output logic           core_hold,
  output logic           done,
  output logic           err
);

  localparam int unsigned WORDS_P = SIZE / 4;
  localparam int unsigned CW      = cnt_width(SIZE);

  loader_state_t state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          we_q, we_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          rx_ready;
  logic          accept;
  logic          pk_clr;
  logic          word_valid;
  logic [31:0]   word;

  // Ready depends only on registered state so the accept path has no loop.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      HDR:     rx_ready = 1'b1;
      DATA:    rx_ready = (wcnt_q != n_q);
      default: rx_ready = 1'b0;
    endcase
  end

  assign accept       = bus.rx_valid && rx_ready;
  assign bus.rx_ready = rx_ready;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;

  assign core_hold = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_en    (accept),
    .byte_in    (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next state, word bookkeeping and the registered cache write.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    pk_clr  = 1'b0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HDR;
          pk_clr  = 1'b1;
          wcnt_d  = '0;
        end
      end
      HDR: begin
        if (word_valid) begin
          if (word == 32'd0) begin
            state_d = DONE;
          end else if (word > 32'(WORDS_P)) begin
            state_d = ERR;
          end else begin
            n_d     = word[CW-1:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // Last write is already out; leave one cycle after it.
        if (wcnt_q == n_q) begin
          state_d = DONE;
        end else if (word_valid) begin
          we_d    = 1'b1;
          waddr_d = BASE + (32'(wcnt_q) << 2);
          wdata_d = word;
          wcnt_d  = wcnt_q + 1'b1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader against a byte-image write model.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;

  always #5 clk = ~clk;

  imem_loader_if ifa ();
  imem_loader_if ifb ();

  logic start_a, start_b;
  logic hold_a, done_a, err_a, hold_b, done_b, err_b;

  assign start_a      = start & ~sel;
  assign start_b      = start & sel;
  assign ifa.rx_data  = rx_data;
  assign ifa.rx_valid = rx_valid & ~sel;
  assign ifb.rx_data  = rx_data;
  assign ifb.rx_valid = rx_valid & sel;

  imem_loader #(.SIZE(8192), .BASE(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(ifa.master),
    .core_hold(hold_a), .done(done_a), .err(err_a)
  );

  imem_loader #(.SIZE(8192), .BASE(32'h0000_1000)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(ifb.master),
    .core_hold(hold_b), .done(done_b), .err(err_b)
  );

  wire        rdy   = sel ? ifb.rx_ready : ifa.rx_ready;
  wire        we    = sel ? ifb.we       : ifa.we;
  wire [31:0] waddr = sel ? ifb.waddr    : ifa.waddr;
  wire [31:0] wdata = sel ? ifb.wdata    : ifa.wdata;
  wire        hold  = sel ? hold_b       : hold_a;
  wire        done  = sel ? done_b       : done_a;
  wire        err   = sel ? err_b        : err_a;

  int checks = 0;
  int errors = 0;

  // Write monitor: sampled mid-cycle, away from the active edge.
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int   cyc = 0, first_we_cyc = 0, last_we_cyc = 0, hold_fall_cyc = 0, wide_cnt = 0;
  logic we_prev = 1'b0, hold_prev = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (we === 1'b1) begin
      if (wq_addr.size() == 0) first_we_cyc <= cyc;
      wq_addr.push_back(waddr);
      wq_data.push_back(wdata);
      last_we_cyc <= cyc;
      if (we_prev) wide_cnt <= wide_cnt + 1;
    end
    if (hold_prev && !hold) hold_fall_cyc <= cyc;
    we_prev   <= we;
    hold_prev <= hold;
  end

  // Image of the data bytes sent in the current load (reference model input).
  logic [7:0] img[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Offer a byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rdy !== 1'b1 && t < 50) begin
      step(1);
      t++;
    end
    if (t >= 50) chk("rdy_timeout", {31'd0, rdy}, 32'd1);
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (gap) step(1);
      send_byte(w[8*k +: 8]);
    end
  endtask

  // Random data words, recorded into the image.
  task automatic send_data(input int n, input bit gap);
    logic [7:0] b;
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom_range(255));
      img.push_back(b);
      if (gap) step(1);
      send_byte(b);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    img.delete();
  endtask

  // Expected writes: word i is image bytes 4i..4i+3 LE, at base + 4i.
  task automatic check_writes(input string tag, input logic [31:0] base, input int n);
    logic [31:0] ew;
    chk({tag, "_count"}, 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      ew = 32'(img[4*i]) + (32'(img[4*i+1]) * 256) + (32'(img[4*i+2]) * 65536)
         + (32'(img[4*i+3]) * 16777216);
      chk({tag, "_addr"}, wq_addr[i], base + 32'(4 * i));
      chk({tag, "_data"}, wq_data[i], ew);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"},   {31'd0, rdy},  32'd0);
    chk({tag, "_we"},    {31'd0, we},   32'd0);
    chk({tag, "_waddr"}, waddr,         32'd0);
    chk({tag, "_wdata"}, wdata,         32'd0);
    chk({tag, "_hold"},  {31'd0, hold}, 32'd1);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_err"},   {31'd0, err},  32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, w0;
    logic [7:0] b;

    // Reset state
    step(2);
    check_reset_vals("reset");
    rst = 1'b0;
    step(1);

    // Spec image: N=4, words 0x13 at full rate
    clear_log();
    w0 = wide_cnt;
    pulse_start();
    chk("rdy_after_start", {31'd0, rdy}, 32'd1);
    send_word(32'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      img.push_back(8'h13); img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h00);
      send_word(32'h0000_0013, 1'b0);
    end
    chk("last_we_cycle_we",   {31'd0, we},   32'd1);
    chk("last_we_cycle_rdy",  {31'd0, rdy},  32'd0);
    chk("last_we_cycle_done", {31'd0, done}, 32'd0);
    step(3);
    check_writes("fullrate", 32'h0, 4);
    chk("fullrate_done", {31'd0, done}, 32'd1);
    chk("fullrate_hold", {31'd0, hold}, 32'd0);
    chk("hold_fall_lat", 32'(hold_fall_cyc - last_we_cyc), 32'd1);
    chk("we_spacing",    32'(last_we_cyc - first_we_cyc), 32'd12);
    chk("fullrate_wide", 32'(wide_cnt - w0), 32'd0);

    // Zero-length header: straight to DONE
    clear_log();
    pulse_start();
    chk("zero_done_cleared", {31'd0, done}, 32'd0);
    send_word(32'd0, 1'b0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_rdy",  {31'd0, rdy},  32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    step(3);
    chk("zero_rdy_held", {31'd0, rdy}, 32'd0);
    rx_valid = 1'b0;
    chk("zero_writes", 32'(wq_addr.size()), 32'd0);

    // Random N with rx_valid toggling every other cycle
    clear_log();
    w0 = wide_cnt;
    n  = $urandom_range(5, 2);
    pulse_start();
    send_word(32'(n), 1'b1);
    send_data(n, 1'b1);
    step(3);
    check_writes("gapped", 32'h0, n);
    chk("gapped_wide", 32'(wide_cnt - w0), 32'd0);
    chk("gapped_done", {31'd0, done}, 32'd1);

    // Capacity boundary: N = SIZE/4 is accepted and fills the cache
    clear_log();
    pulse_start();
    send_word(32'd2048, 1'b0);
    send_data(2048, 1'b0);
    step(3);
    check_writes("maxlen", 32'h0, 2048);
    chk("maxlen_done", {31'd0, done}, 32'd1);

    // Oversized header -> ERR, sticky, start ignored
    clear_log();
    pulse_start();
    send_word(32'h0000_0801, 1'b0);
    chk("err_flag", {31'd0, err},  32'd1);
    chk("err_hold", {31'd0, hold}, 32'd1);
    chk("err_rdy",  {31'd0, rdy},  32'd0);
    pulse_start();
    step(2);
    chk("err_sticky",    {31'd0, err}, 32'd1);
    chk("err_rdy_start", {31'd0, rdy}, 32'd0);
    chk("err_writes", 32'(wq_addr.size()), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);

    // Reset mid-load, then a fresh N=1 load
    clear_log();
    pulse_start();
    send_word(32'd3, 1'b0);
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(255)) | 8'h01;
      send_byte(b);
    end
    #1 rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    step(1);
    rst = 1'b0;
    step(1);
    clear_log();
    pulse_start();
    send_word(32'd1, 1'b0);
    send_data(1, 1'b0);
    step(3);
    check_writes("after_rst", 32'h0, 1);

    // Non-zero BASE, then restart from DONE
    sel = 1'b1;
    step(1);
    clear_log();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_data(2, 1'b0);
    step(3);
    check_writes("base_a", 32'h0000_1000, 2);
    chk("base_done", {31'd0, done}, 32'd1);
    clear_log();
    pulse_start();
    chk("base_done_clr", {31'd0, done}, 32'd0);
    send_word(32'd1, 1'b0);
    send_data(1, 1'b0);
    step(3);
    check_writes("base_b", 32'h0000_1000, 1);
    chk("base_done2", {31'd0, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the L1 instruction cache: accepts a byte stream over a valid/ready link, packs it into little-endian 32-bit words and drives the cache write port. It holds the pipeline (fetch/decode stall and flush) until the image is fully written. It is the producer side of the instruction-memory interface that the fetch stage only reads.

## Interface
- SIZE, 8192, instruction cache capacity in bytes; power of two, at least 8
- BASE, 32'h0000_0000, byte address of the first loaded word
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- we  out  1  cache write strobe, one cycle per word
- waddr  out  32  cache byte address, word aligned
- wdata  out  32  cache write data
- core_hold  out  1  drives fetch/decode stall and decode flush
- done  out  1  image loaded
- err  out  1  header length exceeded capacity; sticky until rst

## Operation
- States: IDLE, HDR, DATA, DONE, ERR.
- A byte is accepted when rx_valid and rx_ready are both high at a rising edge.
- IDLE: rx_ready=0. On start, go to HDR.
- HDR: rx_ready=1. Accept 4 bytes, little-endian, forming word count N (first byte is N[7:0]).
  - On the edge accepting the 4th byte: N==0 goes to DONE; N>SIZE/4 goes to ERR; otherwise go to DATA.
- DATA: accept 4·N bytes. Word i (0-based) is packed little-endian and written to BASE+4·i.
  - Waddr arithmetic is 32-bit modulo 2^32. No other range check is applied beyond N≤SIZE/4.
- DONE: done=1, core_hold=0, rx_ready=0. start goes to HDR and clears done. rx_valid is ignored.
- ERR: core_hold=1, err=1, rx_ready=0. Leaves only on rst.
- start outside IDLE and DONE is ignored.
- Bytes offered while rx_ready=0 are not consumed.
- Reset values: state=IDLE, rx_ready=0, we=0, waddr=0, wdata=0, core_hold=1, done=0, err=0. Byte and word counters are cleared.
- rst asserted mid-load aborts immediately and returns to IDLE. Words already written stay in the cache. A new start restarts from the header.

## Timing
- we/waddr/wdata are registered. They are valid for exactly one cycle, the cycle after the edge that accepts a word's 4th byte.
- Back-to-back bytes at full rate give one write every 4 cycles. There are no bubbles beyond those caused by rx_valid.
- After the 4th byte of word N-1 is accepted, rx_ready=0. The final we cycle occurs with state still DATA.
- The next edge moves the state to DONE. core_hold and done change there, so core_hold falls one cycle after the final we.
- HDR to DONE (N==0) and HDR to ERR take effect at the 4th-header-byte edge. The flags update in the following cycle.
- Byte-accept to write latency is 1 cycle. start to rx_ready=1 is 1 cycle.

## Structure
- Shared package riscv_pkg holds:
  - the loader_state_t enum (IDLE, HDR, DATA, DONE, ERR)
  - the localparam WORDS=SIZE/4
  - the count width $clog2(WORDS)+1
- One sub-module: byte_packer.
  - Contains the 2-bit byte counter and the 32-bit little-endian shift/assemble register.
  - Emits a word_valid pulse with the word.
  - The FSM reuses it for both the header and data words.

## Test plan
- Reset then start; stream 04 00 00 00 followed by bytes 13 00 00 00 ×4 at full rate:
  - exactly 4 we pulses, at waddr 0,4,8,C with wdata 0000_0013
  - core_hold falls the cycle after the 4th we; done=1
- Header 00 00 00 00 -> no we; DONE one edge later; rx_ready low afterwards.
- Header 01 08 00 00 (N=2049 > 2048 for SIZE=8192) -> ERR; err=1; core_hold stays 1; start ignored until rst.
- N=2 with rx_valid toggled every other cycle -> same two writes (waddr 0,4); no duplicated or dropped bytes; every we pulse is exactly one cycle wide.
- rst asserted after 6 data bytes of an N=3 load:
  - all outputs return to reset values asynchronously
  - a fresh start with N=1 writes waddr 0
- BASE=32'h0000_1000, N=2, then start from DONE with N=1:
  - the first load writes 1000 and 1004
  - the second load writes 1000; done clears in the cycle after start
